// File: rtl/comp_operand_loader.sv
// Operand loader for the 8-bit magnitude comparator: sync, debounce, edge-detect and nibble capture.
// Optional in-order load checking is enabled by defining LOAD_ORDER_EN.
module comp_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic [3:0] Y,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [3:0] load_mask,
  output logic       operands_valid,
  output logic       valid_pulse,
  output logic       load_err
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_pb;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_db;
  logic [3:0]       r_db_prev;
  logic [CNT_W-1:0] r_cnt [4];

  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_mask;
  logic       r_valid;
  logic       r_pulse;

  logic [3:0] w_press;
  logic       w_full;
  logic [3:0] w_load;
  logic [3:0] w_mask_d;
  logic       w_valid_d;

  assign w_pb = {PB4, PB3, PB2, PB1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 4'b0000;
      r_sync2   <= 4'b0000;
      r_db      <= 4'b0000;
      r_db_prev <= 4'b0000;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_pb;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_prev;
  assign w_full  = (r_mask == 4'b1111);

`ifdef LOAD_ORDER_EN
  logic [3:0] w_expect;
  logic       w_err_set;
  logic       r_err;

  // Masks only ever fill from bit 0 upward, so the lowest clear bit is the next legal button.
  always_comb begin
    w_expect  = w_full ? 4'b0001 : (~r_mask & (r_mask + 4'd1));
    w_load    = 4'b0000;
    w_mask_d  = r_mask;
    w_err_set = 1'b0;
    if (w_press != 4'b0000) begin
      if (w_press == w_expect) begin
        w_load   = w_press;
        w_mask_d = w_full ? w_press : (r_mask | w_press);
      end else begin
        w_err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | w_err_set;
  end

  assign load_err = r_err;
`else
  always_comb begin
    w_load   = w_press;
    w_mask_d = r_mask;
    if (w_press != 4'b0000) w_mask_d = w_full ? w_press : (r_mask | w_press);
  end

  assign load_err = 1'b0;
`endif

  assign w_valid_d = (w_mask_d == 4'b1111);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_mask  <= 4'b0000;
      r_valid <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      if (w_load[0]) r_a[3:0] <= Y;
      if (w_load[1]) r_a[7:4] <= Y;
      if (w_load[2]) r_b[3:0] <= Y;
      if (w_load[3]) r_b[7:4] <= Y;
      r_mask  <= w_mask_d;
      r_valid <= w_valid_d;
      r_pulse <= w_valid_d & ~r_valid;
    end
  end

  assign A              = r_a;
  assign B              = r_b;
  assign load_mask      = r_mask;
  assign operands_valid = r_valid;
  assign valid_pulse    = r_pulse;

endmodule
